// File: rtl/maze_pkg.sv
// Shared types and constants for the maze memory arbiter.
// MAZE_ARB_RR_EN in the top selects solver/viewer round-robin.
package maze_pkg;

  localparam int ADDR_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RDATA
  } state_t;

  localparam logic [1:0] LOADER = 2'd0;
  localparam logic [1:0] SOLVER = 2'd1;
  localparam logic [1:0] VIEWER = 2'd2;

  function automatic logic [2:0] onehot(input logic [1:0] idx);
    return 3'b001 << idx;
  endfunction

endpackage

// File: rtl/arb_rr2.sv
// Two-way round-robin picker; pick 0 = req[0], 1 = req[1].
// ptr = 0 favours req[0] when both request.
module arb_rr2 (
  input  logic       CLK,
  input  logic       RST,
  input  logic [1:0] req,
  input  logic       take,
  output logic       pick
);

  logic ptr;

  always_comb pick = req[1] & (~req[0] | ptr);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)
      ptr <= 1'b0;
    else if (take)
      ptr <= ~pick;
  end

endmodule

// File: rtl/maze_mem_arbiter.sv
// Three-requester arbiter for the single-bit maze wall memory.
// Define MAZE_ARB_RR_EN for round-robin between solver and viewer.
module maze_mem_arbiter
  import maze_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [2:0]        req,
  input  logic [2:0]        we,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [ADDR_W-1:0] addr2,
  input  logic [2:0]        wdata,
  output logic [2:0]        gnt,
  output logic [2:0]        rvalid,
  output logic              rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic              mem_wdata,
  input  logic              mem_rdata,
  output logic              busy
);

  state_t            state;
  logic [1:0]        win;
  logic              wr;
  logic [1:0]        sv_pick;
  logic [1:0]        pick;
  logic [ADDR_W-1:0] sel_addr;
  logic              sel_we;
  logic              sel_wdata;

`ifdef MAZE_ARB_RR_EN
  logic rr_pick;
  logic rr_take;

  // Pointer moves only when solver or viewer actually wins.
  assign rr_take = (state == IDLE) & ~req[LOADER] & (req[SOLVER] | req[VIEWER]);

  arb_rr2 u_rr (
    .CLK  (CLK),
    .RST  (RST),
    .req  (req[2:1]),
    .take (rr_take),
    .pick (rr_pick)
  );

  always_comb sv_pick = rr_pick ? VIEWER : SOLVER;
`else
  always_comb sv_pick = req[SOLVER] ? SOLVER : VIEWER;
`endif

  always_comb pick = req[LOADER] ? LOADER : sv_pick;

  always_comb begin
    sel_addr  = addr0;
    sel_we    = we[0];
    sel_wdata = wdata[0];
    case (pick)
      SOLVER: begin
        sel_addr  = addr1;
        sel_we    = we[1];
        sel_wdata = wdata[1];
      end
      VIEWER: begin
        sel_addr  = addr2;
        sel_we    = we[2];
        sel_wdata = wdata[2];
      end
      default: ;
    endcase
  end

  assign rdata = (state == RDATA) & mem_rdata;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      win       <= LOADER;
      wr        <= 1'b0;
      gnt       <= '0;
      rvalid    <= '0;
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_wdata <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            win       <= pick;
            wr        <= sel_we;
            gnt       <= onehot(pick);
            mem_addr  <= sel_addr;
            mem_we    <= sel_we;
            mem_wdata <= sel_wdata;
            busy      <= 1'b1;
            state     <= ACCESS;
          end
        end
        ACCESS: begin
          gnt       <= '0;
          mem_addr  <= '0;
          mem_we    <= 1'b0;
          mem_wdata <= 1'b0;
          if (wr) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            rvalid <= onehot(win);
            state  <= RDATA;
          end
        end
        RDATA: begin
          rvalid <= '0;
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          gnt       <= '0;
          rvalid    <= '0;
          mem_addr  <= '0;
          mem_we    <= 1'b0;
          mem_wdata <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_maze_mem_arbiter.sv
// Directed bench for maze_mem_arbiter with a 256x1 synchronous memory.
// Contention expectations follow MAZE_ARB_RR_EN.
module tb_maze_mem_arbiter;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [2:0] req = '0;
  logic [2:0] we = '0;
  logic [7:0] addr0 = '0;
  logic [7:0] addr1 = '0;
  logic [7:0] addr2 = '0;
  logic [2:0] wdata = '0;
  logic [2:0] gnt;
  logic [2:0] rvalid;
  logic       rdata;
  logic [7:0] mem_addr;
  logic       mem_we;
  logic       mem_wdata;
  logic       mem_rdata = 1'b0;
  logic       busy;

  logic       m [0:255];
  int         checks = 0;
  int         failures = 0;

  maze_mem_arbiter dut (
    .CLK       (CLK),
    .RST       (RST),
    .req       (req),
    .we        (we),
    .addr0     (addr0),
    .addr1     (addr1),
    .addr2     (addr2),
    .wdata     (wdata),
    .gnt       (gnt),
    .rvalid    (rvalid),
    .rdata     (rdata),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .busy      (busy)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    if (mem_we)
      m[mem_addr] <= mem_wdata;
    mem_rdata <= m[mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_gnt;
    int n;
    n = 0;
    do begin
      tick;
      n++;
    end while (gnt == 3'b000 && n < 8);
    if (gnt == 3'b000)
      check("gnt_timeout", 32'(gnt), 32'h1);
  endtask

  initial begin
    for (int i = 0; i < 256; i++)
      m[i] = 1'b0;

    repeat (2) @(posedge CLK);
    #1;
    check("rst_gnt", 32'(gnt), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_mem", 32'({rvalid, mem_we, mem_addr}), 32'h0);
    RST = 1'b0;
    tick;

    // loader write
    req = 3'b001; we = 3'b001; addr0 = 8'h35; wdata = 3'b001;
    tick;
    check("lw_gnt", 32'(gnt), 32'h1);
    check("lw_addr", 32'(mem_addr), 32'h35);
    check("lw_we", 32'(mem_we), 32'h1);
    check("lw_wd", 32'(mem_wdata), 32'h1);
    check("lw_busy", 32'(busy), 32'h1);
    req = 3'b000; we = 3'b000; wdata = 3'b000;
    tick;
    check("lw_idle", 32'({busy, gnt, mem_we}), 32'h0);

    // solver read; inputs change mid-transaction
    req = 3'b010; we = 3'b000; addr1 = 8'h35;
    tick;
    check("sr_gnt", 32'(gnt), 32'h2);
    check("sr_we", 32'(mem_we), 32'h0);
    check("sr_addr", 32'(mem_addr), 32'h35);
    req = 3'b000; we = 3'b010; addr1 = 8'h00;
    tick;
    check("sr_rvalid", 32'(rvalid), 32'h2);
    check("sr_rdata", 32'(rdata), 32'h1);
    check("sr_gnt0", 32'(gnt), 32'h0);
    tick;
    check("sr_done", 32'({busy, rvalid, rdata}), 32'h0);
    we = 3'b000;

    // contention from fresh reset
    RST = 1'b1;
    tick;
    RST = 1'b0;
    req = 3'b110; addr1 = 8'h35; addr2 = 8'h36;
    for (int i = 0; i < 4; i++) begin
      wait_gnt;
`ifdef MAZE_ARB_RR_EN
      check("cont_gnt", 32'(gnt), (i % 2 == 0) ? 32'h2 : 32'h4);
`else
      check("cont_gnt", 32'(gnt), 32'h2);
`endif
      tick;
    end
    req = 3'b000;
    repeat (3) tick;
    check("cont_idle", 32'(busy), 32'h0);

    // loader preemption
    req = 3'b111; we = 3'b000; addr0 = 8'h35;
    wait_gnt;
    check("pre_gnt0", 32'(gnt), 32'h1);
    req = 3'b110;
    tick;
    check("pre_rvalid", 32'(rvalid), 32'h1);
    check("pre_rdata", 32'(rdata), 32'h1);
    wait_gnt;
    check("pre_gnt1", 32'(gnt), 32'h2);
    req = 3'b000;
    repeat (3) tick;

    // reset during a write grant
    req = 3'b001; we = 3'b001; addr0 = 8'h12; wdata = 3'b001;
    tick;
    check("ra_gnt", 32'(gnt), 32'h1);
    RST = 1'b1;
    #1;
    check("ra_gnt0", 32'(gnt), 32'h0);
    check("ra_we0", 32'(mem_we), 32'h0);
    check("ra_busy0", 32'(busy), 32'h0);
    req = 3'b000; we = 3'b000; wdata = 3'b000;
    tick;
    RST = 1'b0;
    tick;
    check("ra_idle", 32'(busy), 32'h0);
    check("ra_nowrite", 32'(m[8'h12]), 32'h0);

    // idle hold
    for (int i = 0; i < 10; i++) begin
      tick;
      check("idle", 32'({busy, gnt, rvalid, mem_we}), 32'h0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
